// File: rtl/m68k_region_decode.sv
// m68k_region_decode: registered 68000 address decoder.
// Decodes each bus cycle against a port-supplied region map, drives one-hot
// chip selects, and terminates the cycle with DTACK_n (after per-region wait
// states and external ready) or BERR_n (after a timeout on a miss or stall).

module m68k_region_decode #(
  parameter int NREGIONS = 16,
  parameter int ADDR_W   = 24,
  parameter int WAIT_W   = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_W-1:0]              cpu_a,
  input  logic                           cpu_as_n,
  input  logic [NREGIONS*ADDR_W-1:0]     region_base,
  input  logic [NREGIONS*5-1:0]          region_width,
  input  logic [NREGIONS*WAIT_W-1:0]     region_wait,
  input  logic [NREGIONS-1:0]            region_en,
  input  logic [NREGIONS-1:0]            region_ready,
  output logic [NREGIONS-1:0]            cs,
  output logic [$clog2(NREGIONS)-1:0]    hit_idx,
  output logic                           dtack_n,
  output logic                           berr_n,
  output logic                           busy
);

  localparam int IDX_W  = $clog2(NREGIONS);
  localparam int TCNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_MISS = 3'd3,
    ST_BERR = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [NREGIONS-1:0] cs_q, cs_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                dtack_n_q, dtack_n_d;
  logic                berr_n_q, berr_n_d;
  logic                busy_q, busy_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                prev_as_q, prev_as_d;
  // arm_q: AS_n has been seen high since reset, so a low level after reset
  // release is not mistaken for a fresh falling edge.
  logic                arm_q, arm_d;

  logic [NREGIONS-1:0] match_s;
  logic                any_hit_s;
  logic [IDX_W-1:0]    match_idx_s;
  logic                start_s;
  logic                timeout_s;

  // Per-region address compare against the live CPU address.
  always_comb begin
    match_s = {NREGIONS{1'b0}};
    for (int i = 0; i < NREGIONS; i++) begin
      if (int'(region_width[i*5 +: 5]) >= ADDR_W) begin
        match_s[i] = region_en[i];
      end else begin
        match_s[i] = region_en[i] &
                     ((cpu_a >> region_width[i*5 +: 5]) ==
                      (region_base[i*ADDR_W +: ADDR_W] >> region_width[i*5 +: 5]));
      end
    end
  end

  // Priority encode the matches; the lowest index wins on overlap.
  always_comb begin
    any_hit_s   = 1'b0;
    match_idx_s = {IDX_W{1'b0}};
    for (int i = NREGIONS - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        any_hit_s   = 1'b1;
        match_idx_s = IDX_W'(i);
      end else begin
        any_hit_s   = any_hit_s;
      end
    end
  end

  assign start_s   = ~cpu_as_n & prev_as_q & arm_q;
  assign timeout_s = (tcnt_q == TCNT_W'(TIMEOUT - 2));

  // Bus-cycle state machine: next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    hit_idx_d = hit_idx_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    prev_as_d = cpu_as_n;
    arm_d     = arm_q | cpu_as_n;
    case (state_q)
      ST_IDLE: begin
        dtack_n_d = 1'b1;
        berr_n_d  = 1'b1;
        if (start_s && any_hit_s) begin
          cs_d      = {{(NREGIONS-1){1'b0}}, 1'b1} << match_idx_s;
          hit_idx_d = match_idx_s;
          wcnt_d    = region_wait[match_idx_s*WAIT_W +: WAIT_W];
          tcnt_d    = {TCNT_W{1'b0}};
          state_d   = ST_WAIT;
        end else if (start_s) begin
          cs_d    = {NREGIONS{1'b0}};
          tcnt_d  = {TCNT_W{1'b0}};
          state_d = ST_MISS;
        end else begin
          cs_d = {NREGIONS{1'b0}};
        end
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (cpu_as_n) begin
          cs_d    = {NREGIONS{1'b0}};
          state_d = ST_IDLE;
        end else if ((wcnt_q == {WAIT_W{1'b0}}) && region_ready[hit_idx_q]) begin
          dtack_n_d = 1'b0;
          state_d   = ST_ACK;
        end else if (timeout_s) begin
          cs_d     = {NREGIONS{1'b0}};
          berr_n_d = 1'b0;
          state_d  = ST_BERR;
        end else if (wcnt_q != {WAIT_W{1'b0}}) begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      ST_ACK: begin
        if (cpu_as_n) begin
          cs_d      = {NREGIONS{1'b0}};
          dtack_n_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_MISS: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (cpu_as_n) begin
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          berr_n_d = 1'b0;
          state_d  = ST_BERR;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_BERR: begin
        if (cpu_as_n) begin
          berr_n_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_BERR;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cs_d      = {NREGIONS{1'b0}};
        dtack_n_d = 1'b1;
        berr_n_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cs_q      <= {NREGIONS{1'b0}};
      hit_idx_q <= {IDX_W{1'b0}};
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      wcnt_q    <= {WAIT_W{1'b0}};
      tcnt_q    <= {TCNT_W{1'b0}};
      prev_as_q <= 1'b1;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      hit_idx_q <= hit_idx_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      busy_q    <= busy_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      prev_as_q <= prev_as_d;
      arm_q     <= arm_d;
    end
  end

  assign cs      = cs_q;
  assign hit_idx = hit_idx_q;
  assign dtack_n = dtack_n_q;
  assign berr_n  = berr_n_q;
  assign busy    = busy_q;

endmodule

// File: doc/m68k_region_decode.md
# m68k_region_decode

Parametrised, registered 68000 address decoder with per-region wait states, external-ready stretching and bus-error timeout. It sits between the 68000 core and the PCB's memory/IO blocks. Its region map comes in through ports, so a single instance serves every supported PCB. It produces one-hot chip selects, DTACK_n and BERR_n from a single bus-cycle state machine.

## Interface
Parameters:
- NREGIONS, 16, number of decode regions
- ADDR_W, 24, CPU address width
- WAIT_W, 4, width of per-region wait-state count
- TIMEOUT, 64, cycles from AS_n assertion to BERR_n on a miss or stalled access (must be ≥ 2^WAIT_W + 2)

Ports:
- clk  in  1  system clock. All inputs are synchronous to clk.
- reset_n  in  1  asynchronous, active-low reset
- cpu_a  in  ADDR_W  CPU byte address
- cpu_as_n  in  1  address strobe, active low
- region_base  in  NREGIONS*ADDR_W  base address of region i, packed at [i*ADDR_W +: ADDR_W]
- region_width  in  NREGIONS*5  number of low address bits ignored for region i
- region_wait  in  NREGIONS*WAIT_W  wait states for region i
- region_en  in  NREGIONS  region enable
- region_ready  in  NREGIONS  external ready for region i (tie high if unused)
- cs  out  NREGIONS  registered one-hot chip selects
- hit_idx  out  $clog2(NREGIONS)  index of the active region
- dtack_n  out  1  data acknowledge, active low
- berr_n  out  1  bus error, active low
- busy  out  1  high whenever the state machine is not in IDLE

## Operation
- Match rule: match[i] = region_en[i] & ((cpu_a >> w) == (region_base[i] >> w)), where w = region_width[i].
  - w ≥ ADDR_W matches every address.
  - Overlapping matches resolve to the lowest index.
- States:
  - IDLE
    - cpu_as_n low and the previous sample of cpu_as_n high (falling edge): latch cpu_a and evaluate matches.
    - Any hit: set cs[idx] and hit_idx, load wcnt = region_wait[idx], clear tcnt, go to WAIT.
    - No hit: clear tcnt, go to MISS.
  - WAIT
    - If wcnt ≠ 0, decrement wcnt.
    - If wcnt == 0 and region_ready[idx] is high: dtack_n goes low, go to ACK.
  - ACK: hold cs and dtack_n until cpu_as_n is high, then clear cs, release dtack_n, go to IDLE.
  - MISS: no cs asserted. Count tcnt.
  - BERR: berr_n low until cpu_as_n is high, then release berr_n and go to IDLE.
- tcnt increments every cycle in WAIT and MISS.
  - If tcnt reaches TIMEOUT-1 before any other exit, assert berr_n and go to BERR. In WAIT, also clear cs.
- cpu_as_n high while in WAIT or MISS (aborted cycle): clear cs, no dtack_n, no berr_n, go to IDLE.
- The address is latched at the start of the cycle. Changes to cpu_a or the region map mid-cycle do not affect cs.
- region_ready is sampled only when wcnt == 0.
- dtack_n and berr_n are never asserted together.
- Back-to-back cycles: a new falling edge of cpu_as_n is only detected in IDLE, after cpu_as_n has been seen high.

## Timing
- Reset values (asynchronous): cs = 0, hit_idx = 0, dtack_n = 1, berr_n = 1, busy = 0, state IDLE, previous-AS register = 1.
- All outputs are registered.
- Edge k: cpu_as_n is first sampled low.
  - cs and busy are valid after edge k.
  - With region_wait = N and ready held high, dtack_n goes low after edge k+1+N.
- A ready stall adds one cycle per low sample of region_ready.
- Release: cpu_as_n sampled high at edge m → cs = 0, dtack_n = 1 or berr_n = 1, busy = 0 after edge m.
- Miss: berr_n goes low after edge k+TIMEOUT-1.
- A reset asserted mid-cycle clears everything immediately. After reset deasserts with cpu_as_n already low, no cycle starts until cpu_as_n goes high and low again.

## Test plan
- Map region0 = 0x000000/w18/wait0 and region1 = 0xC00000/w14/wait2; read 0x03FFFE → cs = 0x0001 one cycle after AS, dtack_n low 2 cycles after AS detection, release 1 cycle after AS rises.
- Read 0xC03FFE → cs = 0x0002, hit_idx = 1, dtack_n low 4 cycles after AS detection. Read 0xC04000 → miss, berr_n low after TIMEOUT-1 cycles, cs stays 0.
- Overlap: region2 = 0x400000/w1 and region3 = 0x400000/w3, access 0x400000 → cs = 0x0004 only. Disable region2 → cs = 0x0008.
- Ready stall: region1 with region_ready[1] low for 5 cycles → dtack_n delayed exactly 5 cycles. Ready held low permanently → berr_n at TIMEOUT-1 and cs cleared.
- Abort: AS rises during WAIT with wcnt = 1 → no dtack_n or berr_n, cs = 0 and busy = 0 the next cycle. The next AS falling edge decodes normally.
- Reset asserted in ACK with cpu_as_n held low → outputs return to reset values immediately. No new cycle after reset release until AS toggles high then low.
